inst_mem_resp: RTL and testbench



---
 rtl/riscv_pkg.sv | 20 ++
 rtl/imem_array.sv | 31 +++
 rtl/inst_mem_resp.sv | 124 ++++++++++++
 tb/tb_inst_mem_resp.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg : fetch error codes, NOP encoding and fetch-responder FSM states
// Revision  : 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;

   localparam logic [31:0] RV_NOP = 32'h00000013;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_array : DEPTH_WORDS x 32 block-RAM style store, read-before-write
// Revision   : 1.0
// ---------------------------------------------------------------------------
module imem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // Both updates are non-blocking, so a same-edge write is not seen by the read.
   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
      if (re) r_rdata <= r_mem[raddr];
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/inst_mem_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_mem_resp : instruction-fetch responder with fixed latency and flush
// Revision      : 1.0
// ---------------------------------------------------------------------------
module inst_mem_resp
   import riscv_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] NOP_INST    = RV_NOP
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [31:0]                    req_addr,
   input  logic                           flush,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [31:0]                    resp_inst,
   output logic [31:0]                    resp_addr,
   output logic [1:0]                     resp_err,
   input  logic                           ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data,
   output logic                           busy
);

   localparam int         AW         = $clog2(DEPTH_WORDS);
   localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

   generate
      if (LATENCY < 1 || LATENCY > 15 || DEPTH_WORDS < 2 ||
          (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_cfg_check
         $fatal(1, "inst_mem_resp: LATENCY must be 1..15 and DEPTH_WORDS a power of two >= 2");
      end
   endgenerate

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_resp_addr;
   logic [1:0]  r_resp_err;
   logic        r_inst_ok;
   logic [1:0]  w_err;
   logic        w_accept;
   logic        w_enter_resp;
   logic [31:0] w_rdata;

   assign w_accept     = (r_state == ST_IDLE) && req_valid && !flush;
   assign w_enter_resp = (r_state == ST_WAIT) && !flush && (r_cnt == 4'd0);

   always_comb begin
      w_err = ERR_OK;
      if (r_addr[1:0] != 2'b00)
         w_err = ERR_MISALIGN;
      else if (r_addr[31:2] >= 30'(DEPTH_WORDS))
         w_err = ERR_RANGE;
   end

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .we    (ld_en && rst),
      .waddr (ld_addr),
      .wdata (ld_data),
      .re    (w_enter_resp && (w_err == ERR_OK)),
      .raddr (r_addr[AW+1:2]),
      .rdata (w_rdata)
   );

   // Every accepted fetch passes through WAIT (even LATENCY==1) so resp_valid
   // rises exactly LATENCY edges after acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_BOOT;
         r_cnt       <= 4'd0;
         r_addr      <= 32'd0;
         r_resp_addr <= 32'd0;
         r_resp_err  <= ERR_OK;
         r_inst_ok   <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: r_state <= ST_IDLE;
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr  <= req_addr;
                  r_cnt   <= C_CNT_LOAD;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state     <= ST_RESP;
                  r_resp_addr <= r_addr;
                  r_resp_err  <= w_err;
                  r_inst_ok   <= (w_err == ERR_OK);
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (flush || resp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_BOOT;
         endcase
      end
   end

   // Array output has no reset; r_inst_ok forces NOP until a good read lands.
   assign resp_inst  = r_inst_ok ? w_rdata : NOP_INST;
   assign resp_addr  = r_resp_addr;
   assign resp_err   = r_resp_err;
   assign resp_valid = (r_state == ST_RESP);
   assign req_ready  = (r_state == ST_IDLE);
   assign busy       = (r_state == ST_WAIT) || (r_state == ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_mem_resp : scenario tasks plus randomized fetches against a memory model
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_inst_mem_resp;

   localparam int          DEPTH = 256;
   localparam int          LAT   = 2;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'd0;
   logic        flush = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_inst;
   logic [31:0] resp_addr;
   logic [1:0]  resp_err;
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = 8'd0;
   logic [31:0] ld_data = 32'd0;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] model_mem [DEPTH];

   inst_mem_resp #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .NOP_INST    (NOP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_inst  (resp_inst),
      .resp_addr  (resp_addr),
      .resp_err   (resp_err),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Expected {err, inst} straight from the fetch rules.
   function automatic logic [33:0] model_fetch(input logic [31:0] a);
      logic [7:0] idx;
      idx = a[9:2];
      if (a[1:0] != 2'b00) return {2'b01, NOP};
      if (a >= 32'(DEPTH * 4)) return {2'b10, NOP};
      return {2'b00, model_mem[idx]};
   endfunction

   task automatic do_load(input logic [7:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
      model_mem[a] = d;
   endtask

   // Issues one fetch from IDLE, stalls the response for 'stall' cycles, then takes it.
   task automatic fetch(input logic [31:0] a, input int stall,
                        output logic [31:0] inst, output logic [31:0] ra,
                        output logic [1:0] err, output int lat, output bit held);
      int n;
      req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      lat = n; inst = resp_inst; ra = resp_addr; err = resp_err; held = 1'b1;
      repeat (stall) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b1 || resp_inst !== inst || resp_addr !== ra ||
             resp_err !== err || req_ready !== 1'b0) held = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #3;
      n_vec++;
      if ({resp_valid, req_ready, busy, resp_err} !== 5'b0 || resp_inst !== NOP || resp_addr !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_values: valid=%b ready=%b busy=%b err=%b inst=%h addr=%h, want 0 0 0 00 %h 0",
                  resp_valid, req_ready, busy, resp_err, resp_inst, resp_addr, NOP);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      n_vec++;
      if (req_ready !== 1'b0) begin n_bad++; $display("FAIL boot_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
      n_vec++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_load_and_fetch;
      logic [31:0] inst, ra; logic [1:0] err; int lat; bit held;
      do_load(8'd0, 32'h00500093);
      do_load(8'd1, 32'h00a00113);
      do_load(8'd2, 32'h002081b3);
      do_load(8'd3, 32'h0000006f);
      fetch(32'h8, 0, inst, ra, err, lat, held);
      n_vec++;
      if (lat !== LAT || inst !== 32'h002081b3 || ra !== 32'h8 || err !== 2'b00) begin
         n_bad++;
         $display("FAIL fetch_ok: lat=%0d inst=%h addr=%h err=%b, want %0d 002081b3 00000008 00", lat, inst, ra, err, LAT);
      end
   endtask

   task automatic test_errors;
      logic [31:0] inst, ra; logic [1:0] err; int lat; bit held;
      fetch(32'h6, 0, inst, ra, err, lat, held);
      n_vec++;
      if (lat !== LAT || inst !== NOP || ra !== 32'h6 || err !== 2'b01) begin
         n_bad++;
         $display("FAIL misalign: lat=%0d inst=%h addr=%h err=%b, want %0d %h 00000006 01", lat, inst, ra, err, LAT, NOP);
      end
      fetch(32'h400, 0, inst, ra, err, lat, held);
      n_vec++;
      if (lat !== LAT || inst !== NOP || ra !== 32'h400 || err !== 2'b10) begin
         n_bad++;
         $display("FAIL range: lat=%0d inst=%h addr=%h err=%b, want %0d %h 00000400 10", lat, inst, ra, err, LAT, NOP);
      end
      fetch(32'h401, 0, inst, ra, err, lat, held);
      n_vec++;
      if (err !== 2'b01 || inst !== NOP) begin
         n_bad++;
         $display("FAIL err_priority: err=%b inst=%h, want 01 %h", err, inst, NOP);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] inst, ra; logic [1:0] err; int lat; bit held;
      fetch(32'h4, 5, inst, ra, err, lat, held);
      n_vec++;
      if (held !== 1'b1 || inst !== 32'h00a00113 || err !== 2'b00) begin
         n_bad++;
         $display("FAIL stall_hold: held=%b inst=%h err=%b, want 1 00a00113 00", held, inst, err);
      end
      n_vec++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL after_handshake: valid=%b ready=%b, want 0 1", resp_valid, req_ready);
      end
   endtask

   task automatic test_flush;
      logic [31:0] inst, ra; logic [1:0] err; int lat; bit held; bit seen;
      req_valid = 1'b1; flush = 1'b1; req_addr = 32'h4;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_idle: busy=%b ready=%b, want 0 1", busy, req_ready);
      end
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_wait: busy=%b ready=%b, want 0 1", busy, req_ready);
      end
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_resp: seen=%b want 0", seen); end
      fetch(32'h0, 0, inst, ra, err, lat, held);
      n_vec++;
      if (inst !== 32'h00500093 || err !== 2'b00 || lat !== LAT) begin
         n_bad++;
         $display("FAIL post_flush_fetch: inst=%h err=%b lat=%0d, want 00500093 00 %0d", inst, err, lat, LAT);
      end
   endtask

   task automatic test_ld_collision;
      logic [31:0] inst, ra; logic [1:0] err; int lat; bit held;
      req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (LAT - 1) begin @(posedge clk); #1; end
      ld_en = 1'b1; ld_addr = 8'd1; ld_data = 32'hdeadbeef;
      @(posedge clk); #1;
      ld_en = 1'b0;
      model_mem[1] = 32'hdeadbeef;
      n_vec++;
      if (resp_valid !== 1'b1 || resp_inst !== 32'h00a00113) begin
         n_bad++;
         $display("FAIL rbw_old_data: valid=%b inst=%h, want 1 00a00113", resp_valid, resp_inst);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      fetch(32'h4, 0, inst, ra, err, lat, held);
      n_vec++;
      if (inst !== 32'hdeadbeef || err !== 2'b00) begin
         n_bad++;
         $display("FAIL refetch_new: inst=%h err=%b, want deadbeef 00", inst, err);
      end
   endtask

   task automatic test_random;
      logic [31:0] inst, ra, a; logic [1:0] err; int lat; bit held;
      logic [33:0] exp;
      int kind, stall;
      for (int i = 0; i < DEPTH; i++) do_load(8'(i), $urandom());
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) do_load(8'($urandom_range(0, DEPTH - 1)), $urandom());
         kind = $urandom_range(0, 9);
         if (kind < 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else if (kind < 8) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
         else if (kind < 9) a = ($urandom() | 32'h400) & 32'hfffffffc;
         else               a = $urandom() | 32'h401;
         stall = $urandom_range(0, 3);
         exp = model_fetch(a);
         fetch(a, stall, inst, ra, err, lat, held);
         n_vec++;
         if ({err, inst} !== exp || ra !== a || lat !== LAT || held !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_fetch[%0d]: addr=%h err=%b inst=%h ra=%h lat=%0d held=%b, want err=%b inst=%h lat=%0d held=1",
                     t, a, err, inst, ra, lat, held, exp[33:32], exp[31:0], LAT);
         end
      end
   endtask

   task automatic test_reset_midop;
      int n;
      req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      #2 rst = 1'b0;
      #1;
      n_vec++;
      if (resp_valid !== 1'b0 || resp_inst !== NOP || busy !== 1'b0 || req_ready !== 1'b0 ||
          resp_addr !== 32'd0 || resp_err !== 2'b00 || n >= 40) begin
         n_bad++;
         $display("FAIL async_reset: valid=%b inst=%h busy=%b ready=%b addr=%h err=%b wait=%0d, want 0 %h 0 0 0 00",
                  resp_valid, resp_inst, busy, req_ready, resp_addr, resp_err, n, NOP);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      n_vec++;
      if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reboot_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
      n_vec++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reboot_idle: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
      end
   endtask

   initial begin
      test_reset();
      test_load_and_fetch();
      test_errors();
      test_backpressure();
      test_flush();
      test_ld_collision();
      test_random();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
